// File: rtl/fact_core_fetch.sv
// fact_core_fetch: pops 32-bit operands from the input FIFO, computes N! with an
// iterative shift-add multiplier (MUL_BITS cycles per multiply step) and pushes the
// 64-bit result to the output FIFO as two words, low word first.
// Operands above MAX_N are flagged illegal and produce {32'hFFFF_FFFF, N}.
// Optional build macro FACT_CYCLE_CNT_EN adds the cycle_cnt output port.
module fact_core_fetch #(
    parameter int MAX_N    = 20,
    parameter int MUL_BITS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        in_empty,
    input  logic [31:0] in_dout,
    output logic        in_rd_en,
    input  logic        out_full,
    output logic        out_wr_en,
    output logic [31:0] out_din,
    output logic        busy,
    output logic        done,
    output logic        err,
`ifdef FACT_CYCLE_CNT_EN
    output logic [31:0] cycle_cnt,
`endif
    output logic [15:0] op_cnt
);

    localparam int BIT_W = (MUL_BITS > 1) ? $clog2(MUL_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        MUL,
        WR_LO,
        WR_HI
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          n_q, n_d;
    logic [63:0]          acc_q, acc_d;
    logic [63:0]          psum_q, psum_d;
    logic [63:0]          mcand_q, mcand_d;
    logic [MUL_BITS-1:0]  mult_q, mult_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 illegal_q, illegal_d;
    logic [15:0]          op_cnt_q, op_cnt_d;
    logic [63:0]          step_sum;

    // Next-state and datapath: one multiplier bit is consumed per MUL cycle, the
    // partial sum feeds the next step's multiplicand when a step completes.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        acc_d     = acc_q;
        psum_d    = psum_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        bit_d     = bit_q;
        illegal_d = illegal_q;
        op_cnt_d  = op_cnt_q;
        step_sum  = psum_q + (mult_q[bit_q] ? mcand_q : 64'd0);

        case (state_q)
            IDLE: begin
                if (en && !in_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                n_d       = in_dout;
                illegal_d = 1'b0;
                if (in_dout > 32'(MAX_N)) begin
                    illegal_d = 1'b1;
                    acc_d     = {32'hFFFF_FFFF, in_dout};
                    state_d   = WR_LO;
                end else if (in_dout <= 32'd1) begin
                    acc_d   = 64'd1;
                    state_d = WR_LO;
                end else begin
                    acc_d   = 64'd1;
                    mcand_d = 64'd1;
                    psum_d  = 64'd0;
                    mult_d  = MUL_BITS'(2);
                    bit_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (bit_q == BIT_W'(MUL_BITS - 1)) begin
                    acc_d  = step_sum;
                    psum_d = 64'd0;
                    bit_d  = '0;
                    if (n_q == 32'(mult_q)) begin
                        state_d = WR_LO;
                    end else begin
                        mult_d  = mult_q + MUL_BITS'(1);
                        mcand_d = step_sum;
                    end
                end else begin
                    psum_d  = step_sum;
                    mcand_d = mcand_q << 1;
                    bit_d   = bit_q + BIT_W'(1);
                end
            end
            WR_LO: begin
                if (!out_full) begin
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                if (!out_full) begin
                    op_cnt_d = op_cnt_q + 16'd1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operand in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            n_q       <= '0;
            acc_q     <= '0;
            psum_q    <= '0;
            mcand_q   <= '0;
            mult_q    <= '0;
            bit_q     <= '0;
            illegal_q <= 1'b0;
            op_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            acc_q     <= acc_d;
            psum_q    <= psum_d;
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            bit_q     <= bit_d;
            illegal_q <= illegal_d;
            op_cnt_q  <= op_cnt_d;
        end
    end

    // FIFO strobes and status decoded from the state register; pushes are gated by out_full.
    always_comb begin
        in_rd_en  = (state_q == FETCH);
        busy      = (state_q != IDLE);
        out_wr_en = ((state_q == WR_LO) || (state_q == WR_HI)) && !out_full;
        out_din   = 32'd0;
        if (out_wr_en) begin
            out_din = (state_q == WR_HI) ? acc_q[63:32] : acc_q[31:0];
        end
        done   = (state_q == WR_HI) && !out_full;
        err    = done && illegal_q;
        op_cnt = op_cnt_q;
    end

`ifdef FACT_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Cycle counter: restarts on each fetch, counts every busy cycle including stalls, holds in IDLE.
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == FETCH) begin
            cyc_d = 32'd1;
        end else if ((state_q != IDLE) && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cycle_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_fact_core_fetch.sv
// Self-checking bench for fact_core_fetch: directed operands plus random ones,
// compared against a factorial reference computed with plain 64-bit arithmetic.
module tb_fact_core_fetch;

   localparam int MAX_N    = 20;
   localparam int MUL_BITS = 5;

   logic        clk;
   logic        reset;
   logic        en;
   logic        in_empty;
   logic [31:0] in_dout;
   logic        in_rd_en;
   logic        out_full;
   logic        out_wr_en;
   logic [31:0] out_din;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] op_cnt;
`ifdef FACT_CYCLE_CNT_EN
   logic [31:0] cycle_cnt;
`endif

   int          compared;
   int          mismatched;
   int          cyc;
   logic [31:0] in_q[$];
   bit          pend;
   logic [31:0] pend_val;
   logic [15:0] exp_cnt;

   fact_core_fetch #(.MAX_N(MAX_N), .MUL_BITS(MUL_BITS)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in_empty  (in_empty),
      .in_dout   (in_dout),
      .in_rd_en  (in_rd_en),
      .out_full  (out_full),
      .out_wr_en (out_wr_en),
      .out_din   (out_din),
      .busy      (busy),
      .done      (done),
      .err       (err),
`ifdef FACT_CYCLE_CNT_EN
      .cycle_cnt (cycle_cnt),
`endif
      .op_cnt    (op_cnt)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result: N! for legal operands, {all ones, N} for illegal ones.
   function automatic logic [63:0] refResult(input logic [31:0] n);
      logic [63:0] r;
      if (n > 32'(MAX_N)) return {32'hFFFF_FFFF, n};
      r = 64'd1;
      for (int i = 2; i <= int'(n); i++) r = r * 64'(i);
      return r;
   endfunction

   // Reference latency from fetch to high-word push with no output stalls.
   function automatic int refLatency(input logic [31:0] n);
      if (n > 32'(MAX_N) || n <= 32'd1) return 4;
      return 4 + (int'(n) - 1) * MUL_BITS;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs mid-cycle, let outputs settle, then model the input FIFO pop.
   task automatic stepCycle(input bit full);
      @(negedge clk);
      cyc++;
      out_full = full;
      in_empty = (in_q.size() == 0);
      in_dout  = pend ? pend_val : $urandom;
      pend     = 1'b0;
      #1;
      checkOutput("rd_wr_exclusive", 64'(in_rd_en & out_wr_en), 64'd0);
      if (!out_wr_en) checkOutput("din_zero_idle", 64'(out_din), 64'd0);
      if (full) checkOutput("no_push_when_full", 64'(out_wr_en), 64'd0);
      if (in_rd_en) begin
         if (in_q.size() == 0) begin
            checkOutput("pop_from_empty", 64'd1, 64'd0);
         end else begin
            pend     = 1'b1;
            pend_val = in_q.pop_front();
         end
      end
   endtask

   // Run one operand (already queued or pushed here) to completion and check words, pulses, timing.
   task automatic applyStimulus(input logic [31:0] n, input int stall, input bit do_push, input bit drop_en);
      logic [63:0] exp;
      bit          ill;
      int          lat;
      int          t_fetch;
      int          t_done;
      int          words;
      int          ofs;
      bit          full;
      exp     = refResult(n);
      ill     = (n > 32'(MAX_N));
      lat     = refLatency(n);
      t_fetch = -1;
      t_done  = -1;
      words   = 0;
      if (do_push) in_q.push_back(n);
      for (int k = 0; k < 400 + stall && t_done < 0; k++) begin
         ofs  = cyc + 1 - t_fetch;
         full = (t_fetch >= 0) && (ofs >= lat - 2) && (ofs < lat - 2 + stall);
         stepCycle(full);
         if (in_rd_en) begin
            t_fetch = cyc;
            if (drop_en) en = 1'b0;
         end
         if (out_wr_en) begin
            if (words == 0) begin
               checkOutput("low_word", 64'(out_din), 64'(exp[31:0]));
               checkOutput("low_no_pulse", 64'({done, err}), 64'd0);
            end else begin
               checkOutput("high_word", 64'(out_din), 64'(exp[63:32]));
               checkOutput("high_done", 64'(done), 64'd1);
               checkOutput("high_err", 64'(err), 64'(ill));
               t_done = cyc;
            end
            words++;
         end else begin
            checkOutput("no_pulse", 64'({done, err}), 64'd0);
         end
      end
      if (t_done < 0 || t_fetch < 0) begin
         checkOutput("timeout", 64'd0, 64'd1);
      end else begin
         checkOutput("latency", 64'(t_done - t_fetch + 1), 64'(lat + stall));
         exp_cnt++;
         stepCycle(1'b0);
         checkOutput("op_cnt", 64'(op_cnt), 64'(exp_cnt));
         checkOutput("busy_after", 64'(busy), 64'd0);
      end
   endtask

   initial begin
      logic [31:0] rn;
      int          st;
      compared   = 0;
      mismatched = 0;
      cyc        = 0;
      pend       = 1'b0;
      pend_val   = '0;
      exp_cnt    = '0;
      reset      = 1'b1;
      en         = 1'b0;
      in_empty   = 1'b1;
      in_dout    = '0;
      out_full   = 1'b0;

      // Reset state: every output low.
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_outputs", 64'({in_rd_en, out_wr_en, busy, done, err}), 64'd0);
      checkOutput("reset_din", 64'(out_din), 64'd0);
      checkOutput("reset_op_cnt", 64'(op_cnt), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // en low holds the core idle even with a queued operand.
      in_q.push_back(32'd5);
      for (int i = 0; i < 5; i++) begin
         stepCycle(1'b0);
         checkOutput("en_low_idle", 64'({busy, in_rd_en}), 64'd0);
      end
      en = 1'b1;
      $display("[TB] directed: 5, 20, 0, 1, 21, stalled 3");
      applyStimulus(32'd5, 0, 1'b0, 1'b0);
      applyStimulus(32'd20, 0, 1'b1, 1'b0);
      applyStimulus(32'd0, 0, 1'b1, 1'b0);
      applyStimulus(32'd1, 0, 1'b1, 1'b0);
      applyStimulus(32'd21, 0, 1'b1, 1'b0);
      applyStimulus(32'h8000_0003, 0, 1'b1, 1'b0);
      applyStimulus(32'd2, 0, 1'b1, 1'b0);
      applyStimulus(32'd3, 10, 1'b1, 1'b0);

      // en dropped mid-operation: the operand finishes and the next queued one waits.
      in_q.push_back(32'd6);
      in_q.push_back(32'd3);
      applyStimulus(32'd6, 0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         stepCycle(1'b0);
         checkOutput("en_drop_idle", 64'({busy, in_rd_en}), 64'd0);
      end
      en = 1'b1;
      applyStimulus(32'd3, 0, 1'b0, 1'b0);

      // Reset in the fifth MUL cycle of N=10: outputs clear at once, operand is lost.
      $display("[TB] reset during multiply");
      in_q.push_back(32'd10);
      for (int k = 0; k < 10 && !in_rd_en; k++) stepCycle(1'b0);
      checkOutput("fetch_seen", 64'(in_rd_en), 64'd1);
      for (int i = 0; i < 5; i++) stepCycle(1'b0);
      checkOutput("mul_busy", 64'(busy), 64'd1);
      @(negedge clk);
      cyc++;
      reset = 1'b1;
      #1;
      checkOutput("midreset_outputs", 64'({in_rd_en, out_wr_en, busy, done, err}), 64'd0);
      checkOutput("midreset_op_cnt", 64'(op_cnt), 64'd0);
      exp_cnt = '0;
      @(negedge clk);
      cyc++;
      reset = 1'b0;
      pend  = 1'b0;
      checkOutput("operand_lost", 64'(in_q.size()), 64'd0);
      applyStimulus(32'd4, 0, 1'b1, 1'b0);

      // Random operands with random output stalls.
      $display("[TB] random operands");
      for (int i = 0; i < 14; i++) begin
         rn = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 24));
         st = $urandom_range(0, 3);
         applyStimulus(rn, st, 1'b1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
